uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Sequencer for the UART receive path: derives the 16x oversample tick from clk, runs start/data/stop
//   framing, checks stop bit, and queues received bytes in a small show-ahead FIFO with valid/ready output.
//   Sits between the rx pin and the byte consumer; replaces free-running s_tick/count hand-offs with one clock.
// PARAMETERS
//   DIV_W       16  width of baud_div
//   FIFO_DEPTH  4   received-byte queue depth (power of 2, >=2)
// PORTS
//   clk         in   1              single system clock; all logic on posedge clk
//   rst_n       in   1              asynchronous, active-low reset
//   en          in   1              receiver enable; low aborts frame, holds tick counter at 0
//   baud_div    in   DIV_W          clk cycles per oversample tick (0 treated as 1)
//   rx          in   1              serial line, idle high, asynchronous to clk
//   dout        out  8              FIFO head byte, valid when dout_valid
//   dout_valid  out  1              FIFO non-empty
//   dout_ready  in   1              consumer accepts head when dout_valid&&dout_ready
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued
//   busy        out  1              FSM not in IDLE
//   frame_err   out  1              1-cycle pulse: stop bit sampled 0
//   overrun     out  1              1-cycle pulse: byte completed while FIFO full, byte dropped
// BEHAVIOUR
//   Reset: all outputs 0; rx synchroniser flops 1; FSM IDLE; tick counter, sample cnt, bit_idx, FIFO ptrs 0.
//   rx passes 2-flop synchroniser (rx_s); all decisions use rx_s.
//   Tick: counter 0..max(baud_div,1)-1; tick=1 for one clk when counter==max-1, then wraps to 0.
//     baud_div change takes effect at next wrap. Counter held 0 and tick=0 while en=0.
//   FSM advances only on tick (except en/reset). sample cnt 4b, bit_idx 3b.
//     IDLE:    rx_s==0 -> START, cnt=0.
//     START:   cnt==7: rx_s==0 -> DATA, cnt=0, bit_idx=0; rx_s==1 -> IDLE (glitch, no flags). else cnt++.
//     DATA:    cnt==15: shift rx_s in LSB-first, cnt=0; bit_idx==7 -> STOP else bit_idx++. else cnt++.
//     STOP:    cnt==15: rx_s==1 -> push byte, IDLE; rx_s==0 -> frame_err, discard, WAIT_HI. else cnt++.
//     WAIT_HI: rx_s==1 -> IDLE (no start detection during break/low line).
//   en=0 any state: FSM -> IDLE next clk, partial byte discarded, no flags; FIFO contents kept.
//   Push occurs the clk after the stop-sample tick; dout_valid rises the following clk.
//   FIFO: show-ahead, dout = mem[rd_ptr]; pointers wrap modulo FIFO_DEPTH.
//     pop = dout_valid&&dout_ready. push when full and no pop -> drop, overrun pulse, contents unchanged.
//     push and pop same clk: both take effect, count unchanged (full case: accepted, no overrun).
//     pop when empty ignored. dout holds last head value when empty (don't-care for checker).
//   frame_err/overrun never assert together; both registered, 1 clk wide.
//   Reset mid-frame: immediate return to reset values; no partial byte ever reaches FIFO.
// STRUCTURE
//   Package uart_pkg: rx_state_t enum {IDLE,START,DATA,STOP,WAIT_HI}; OVS=16; MID_SAMPLE=7;
//     LAST_SAMPLE=15; DATA_BITS=8.
//   Sub-module uart_baud_tick (clk, rst_n, en, baud_div -> tick); FSM and FIFO inline in uart_rx_ctrl.
// TESTING
//   1 baud_div=4, en=1, send 0xA5 (8N1, 64 clk/bit) -> one byte, dout=0xA5, fifo_count=1, no flags.
//   2 rx low 3 ticks then high (glitch) -> FSM returns IDLE, no push, frame_err=0, busy drops.
//   3 send 0x3C with stop bit 0 -> frame_err 1-clk pulse, fifo_count stays 0, FSM waits in WAIT_HI until rx=1.
//   4 dout_ready=0, send 0x01..0x05 -> first 4 queued, overrun pulse on 0x05; then ready=1 pops 01,02,03,04.
//   5 FIFO full, dout_ready=1 on same clk as push of 0x55 -> no overrun, 0x55 queued last, count stays 4.
//   6 rst_n low (or en low) mid-DATA of 0xF0 -> outputs at reset values/FSM IDLE, next frame 0x0F received clean.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and framing constants for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

    localparam int OVS         = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int LAST_SAMPLE = 15;
    localparam int DATA_BITS   = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversample tick generator from clk and a runtime divisor
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] cur_max;

    assign div_in = (baud_div == '0) ? DIV_W'(1) : baud_div;

    // The divisor is sampled live only at the start of a period, so a change lands at the next wrap.
    assign cur_max = (cnt == '0) ? div_in : div_q;
    assign tick    = en && (cnt == cur_max - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= DIV_W'(1);
        end else if (!en) begin
            cnt <= '0;
        end else begin
            if (cnt == '0) begin
                div_q <= div_in;
            end
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: rx sync, 8N1 framing, show-ahead byte FIFO
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic            rx_meta;
    logic            rx_s;
    logic            tick;
    rx_state_t       state;
    logic [3:0]      cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            push_req;
    logic [7:0]      push_data;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            pop;
    logic            do_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .baud_div (baud_div),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == 4'(MID_SAMPLE)) begin
                            // A start bit that is gone by mid-bit is treated as line noise.
                            if (!rx_s) begin
                                state   <= DATA;
                                cnt     <= '0;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (cnt == 4'(LAST_SAMPLE)) begin
                            shreg <= {rx_s, shreg[7:1]};
                            cnt   <= '0;
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (cnt == 4'(LAST_SAMPLE)) begin
                            cnt <= '0;
                            if (rx_s) begin
                                push_req  <= 1'b1;
                                push_data <= shreg;
                                state     <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HI;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    WAIT_HI: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy       = (state != IDLE);
    assign dout_valid = (fifo_count != '0);
    assign dout       = mem[rd_ptr];
    assign full       = (fifo_count == CW'(FIFO_DEPTH));
    assign pop        = dout_valid && dout_ready;

    // A simultaneous pop frees the slot, so a push into a full queue is still accepted.
    assign do_push    = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop;
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !do_push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] baud_div;
    logic        rx;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_ctrl #(
        .DIV_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .baud_div   (baud_div),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counting high cycles catches both missing and over-wide pulses.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1)   ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        rx = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(64);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_data(d);
        rx = stop_bit;
        wait_clks(64);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, dout}, {24'd0, exp});
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        en         = 1'b0;
        baud_div   = 16'd4;
        rx         = 1'b1;
        dout_ready = 1'b0;
        wait_clks(3);

        check("rst_dout",       {24'd0, dout},       32'h00);
        check("rst_dout_valid", {31'd0, dout_valid}, 32'h0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'h0);
        check("rst_busy",       {31'd0, busy},       32'h0);
        check("rst_flags",      {30'd0, frame_err, overrun}, 32'h0);

        rst_n = 1'b1;
        en    = 1'b1;
        wait_clks(20);

        // 1: clean frame
        send_frame(8'hA5, 1'b1);
        wait_clks(16);
        check("t1_count", {29'd0, fifo_count}, 32'd1);
        check("t1_valid", {31'd0, dout_valid}, 32'h1);
        check("t1_busy",  {31'd0, busy},       32'h0);
        check("t1_fe",    fe_cnt,              32'd0);
        check("t1_ov",    ov_cnt,              32'd0);
        pop_check("t1_dout", 8'hA5);
        check("t1_count_after_pop", {29'd0, fifo_count}, 32'd0);

        // 2: start glitch
        rx = 1'b0;
        wait_clks(12);
        check("t2_busy_in_start", {31'd0, busy}, 32'h1);
        rx = 1'b1;
        wait_clks(64);
        check("t2_busy_idle", {31'd0, busy},       32'h0);
        check("t2_count",     {29'd0, fifo_count}, 32'd0);
        check("t2_fe",        fe_cnt,              32'd0);

        // 3: framing error, line held low afterwards
        send_frame(8'h3C, 1'b0);
        wait_clks(64);
        check("t3_fe_pulse",  fe_cnt,              32'd1);
        check("t3_count",     {29'd0, fifo_count}, 32'd0);
        check("t3_wait_hi",   {31'd0, busy},       32'h1);
        rx = 1'b1;
        wait_clks(16);
        check("t3_idle",      {31'd0, busy},       32'h0);

        // 4: overrun on fifth byte
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            wait_clks(8);
        end
        check("t4_ov_pulse", ov_cnt,              32'd1);
        check("t4_count",    {29'd0, fifo_count}, 32'd4);
        check("t4_fe",       fe_cnt,              32'd1);
        pop_check("t4_pop1", 8'h01);
        pop_check("t4_pop2", 8'h02);
        pop_check("t4_pop3", 8'h03);
        pop_check("t4_pop4", 8'h04);
        check("t4_empty",    {31'd0, dout_valid}, 32'h0);

        // 5: push into full FIFO coinciding with a pop
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1);
            wait_clks(8);
        end
        check("t5_full", {29'd0, fifo_count}, 32'd4);
        send_data(8'h55);
        rx = 1'b1;
        k = 0;
        while (busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t5_busy_drop_in_time", {31'd0, (k < 400)}, 32'h1);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        wait_clks(2);
        check("t5_no_overrun", ov_cnt,              32'd1);
        check("t5_count",      {29'd0, fifo_count}, 32'd4);
        wait_clks(64);
        pop_check("t5_pop1", 8'h12);
        pop_check("t5_pop2", 8'h13);
        pop_check("t5_pop3", 8'h14);
        pop_check("t5_pop4", 8'h55);

        // 6a: reset mid-DATA with a byte queued
        send_frame(8'h99, 1'b1);
        wait_clks(8);
        check("t6_pre_count", {29'd0, fifo_count}, 32'd1);
        rx = 1'b0;
        wait_clks(64 * 4);
        check("t6_busy_mid", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("t6_rst_busy",  {31'd0, busy},       32'h0);
        check("t6_rst_count", {29'd0, fifo_count}, 32'd0);
        check("t6_rst_dout",  {24'd0, dout},       32'h00);
        check("t6_rst_flags", {30'd0, frame_err, overrun}, 32'h0);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(64);
        send_frame(8'h0F, 1'b1);
        wait_clks(8);
        check("t6_count_after", {29'd0, fifo_count}, 32'd1);
        check("t6_dout_after",  {24'd0, dout},       32'h0F);

        // 6b: en low mid-DATA keeps FIFO contents
        rx = 1'b0;
        wait_clks(64 * 3);
        en = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("t6_en_busy",  {31'd0, busy},       32'h0);
        check("t6_en_count", {29'd0, fifo_count}, 32'd1);
        wait_clks(20);
        en = 1'b1;
        wait_clks(20);
        send_frame(8'h77, 1'b1);
        wait_clks(8);
        check("t6_en_count2", {29'd0, fifo_count}, 32'd2);
        pop_check("t6_pop1", 8'h0F);
        pop_check("t6_pop2", 8'h77);
        check("t6_fe_total", fe_cnt, 32'd1);
        check("t6_ov_total", ov_cnt, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
